ps2kb_xt_scancode_queue: RTL and testbench

Second-generation PS/2 keyboard back end for the XT core. It takes decoded PS/2 set-2 bytes from the existing shift-register receiver and translates them to XT set-1 codes, including the E0 extended prefix and F0 break sequences. Translated codes are buffered in a parametrised FIFO and presented to the XT keyboard-port logic through an irq/keycode/clear_keycode handshake. It also adds overrun reporting, the pause-core toggle and keyboard-reset injection.

---
 rtl/ps2kb_pkg.sv | 53 +++++
 rtl/ps2kb_code_fifo.sv | 69 ++++++
 rtl/ps2kb_xt_scancode_queue.sv | 160 ++++++++++++++++
 tb/tb_ps2kb_xt_scancode_queue.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2kb_pkg.sv
// ps2kb_pkg: shared definitions for the PS/2 set-2 to XT set-1 keyboard back end.
//   - protocol byte constants (set-2 prefixes/responses, XT status codes)
//   - decoder state enum
//   - xlat(): set-2 make code -> set-1 make code (unmapped codes give 8'h00)
package ps2kb_pkg;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] XT_OVERRUN = 8'hFF;
    localparam logic [7:0] XT_BAT_OK  = 8'hAA;
    localparam logic [7:0] XT_BREAK   = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } kb_state_e;

    function automatic logic [7:0] xlat(input logic [7:0] b);
        logic [7:0] x;
        case (b)
            8'h01: x = 8'h43; 8'h03: x = 8'h3F; 8'h04: x = 8'h3D; 8'h05: x = 8'h3B;
            8'h06: x = 8'h3C; 8'h07: x = 8'h58; 8'h09: x = 8'h44; 8'h0A: x = 8'h42;
            8'h0B: x = 8'h40; 8'h0C: x = 8'h3E; 8'h0D: x = 8'h0F; 8'h0E: x = 8'h29;
            8'h11: x = 8'h38; 8'h12: x = 8'h2A; 8'h14: x = 8'h1D; 8'h15: x = 8'h10;
            8'h16: x = 8'h02; 8'h1A: x = 8'h2C; 8'h1B: x = 8'h1F; 8'h1C: x = 8'h1E;
            8'h1D: x = 8'h11; 8'h1E: x = 8'h03; 8'h21: x = 8'h2E; 8'h22: x = 8'h2D;
            8'h23: x = 8'h20; 8'h24: x = 8'h12; 8'h25: x = 8'h05; 8'h26: x = 8'h04;
            8'h29: x = 8'h39; 8'h2A: x = 8'h2F; 8'h2B: x = 8'h21; 8'h2C: x = 8'h14;
            8'h2D: x = 8'h13; 8'h2E: x = 8'h06; 8'h31: x = 8'h31; 8'h32: x = 8'h30;
            8'h33: x = 8'h23; 8'h34: x = 8'h22; 8'h35: x = 8'h15; 8'h36: x = 8'h07;
            8'h3A: x = 8'h32; 8'h3B: x = 8'h24; 8'h3C: x = 8'h16; 8'h3D: x = 8'h08;
            8'h3E: x = 8'h09; 8'h41: x = 8'h33; 8'h42: x = 8'h25; 8'h43: x = 8'h17;
            8'h44: x = 8'h18; 8'h45: x = 8'h0B; 8'h46: x = 8'h0A; 8'h49: x = 8'h34;
            8'h4A: x = 8'h35; 8'h4B: x = 8'h26; 8'h4C: x = 8'h27; 8'h4D: x = 8'h19;
            8'h4E: x = 8'h0C; 8'h52: x = 8'h28; 8'h54: x = 8'h1A; 8'h55: x = 8'h0D;
            8'h58: x = 8'h3A; 8'h59: x = 8'h36; 8'h5A: x = 8'h1C; 8'h5B: x = 8'h1B;
            8'h5D: x = 8'h2B; 8'h66: x = 8'h0E; 8'h69: x = 8'h4F; 8'h6B: x = 8'h4B;
            8'h6C: x = 8'h47; 8'h70: x = 8'h52; 8'h71: x = 8'h53; 8'h72: x = 8'h50;
            8'h73: x = 8'h4C; 8'h74: x = 8'h4D; 8'h75: x = 8'h48; 8'h76: x = 8'h01;
            8'h77: x = 8'h45; 8'h78: x = 8'h57; 8'h79: x = 8'h4E; 8'h7A: x = 8'h51;
            8'h7B: x = 8'h4A; 8'h7C: x = 8'h37; 8'h7D: x = 8'h49; 8'h7E: x = 8'h46;
            8'h83: x = 8'h41;
            default: x = 8'h00;
        endcase
        return x;
    endfunction

endpackage

// File: rtl/ps2kb_code_fifo.sv
// ps2kb_code_fifo: synchronous FIFO of XT codes with a 1- or 2-entry write port.
//   clock, reset     : clock, synchronous active-high reset
//   flush            : empty the queue; a write in the same cycle becomes the new contents
//   wr_en, wr_two    : write one entry (wr_data0) or two (wr_data0 then wr_data1)
//   pop              : drop the head entry (ignored when empty)
//   head             : entry at the head (undefined contents when count is 0)
//   count            : occupancy 0..FIFO_DEPTH
// A write that does not fit is ignored as a whole, so count never exceeds FIFO_DEPTH.
module ps2kb_code_fifo #(
    parameter int FIFO_DEPTH = 8,
    localparam int CW = $clog2(FIFO_DEPTH + 1),
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          wr_en,
    input  logic          wr_two,
    input  logic [7:0]    wr_data0,
    input  logic [7:0]    wr_data1,
    input  logic          pop,
    output logic [7:0]    head,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, wr_base;
    logic [1:0]    wr_n;
    logic          wr_acc, pop_acc;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        wr_n = 2'd0;
        if (wr_en) wr_n = wr_two ? 2'd2 : 2'd1;
        wr_base = flush ? '0 : wr_ptr;
        wr_acc  = wr_en && (flush || (CW'(wr_n) <= DEPTH_C - count));
        pop_acc = pop && !flush && (count != '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= wr_acc ? AW'(wr_n) : '0;
            count  <= wr_acc ? CW'(wr_n) : '0;
        end else begin
            if (pop_acc) rd_ptr <= rd_ptr + AW'(1);
            if (wr_acc)  wr_ptr <= wr_ptr + AW'(wr_n);
            count <= count + (wr_acc ? CW'(wr_n) : '0) - (pop_acc ? CW'(1) : '0);
        end
    end

    // NOTE: storage is deliberately not reset; count/pointers define validity, and this keeps it RAM-mappable.
    always_ff @(posedge clock) begin
        if (wr_acc) begin
            mem[wr_base] <= wr_data0;
            if (wr_n == 2'd2) mem[wr_base + AW'(1)] <= wr_data1;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ps2kb_xt_scancode_queue.sv
// ps2kb_xt_scancode_queue: PS/2 set-2 byte stream -> queued XT set-1 codes.
//   clock, reset    : clock, synchronous active-high reset
//   rx_valid/rx_data: received set-2 byte strobe
//   rx_error        : receiver error strobe (resyncs decoder, queues an FF overrun)
//   clear_keycode   : host consumed keycode; pops the head while irq is high
//   reset_keyboard  : flush queue, clear overflow, queue AA
//   irq, keycode    : head valid / head code (00 while irq is low)
//   pause_core      : toggled by a break of PAUSE_CODE
//   overflow        : sticky, a code was lost for lack of space
//   fifo_count      : queue occupancy
module ps2kb_xt_scancode_queue
    import ps2kb_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter int         IRQ_GAP    = 2,
    parameter logic [7:0] PAUSE_CODE = 8'h78,
    parameter bit         ENABLE_EXT = 1'b1,
    localparam int        CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    input  logic          rx_error,
    input  logic          clear_keycode,
    input  logic          reset_keyboard,
    output logic          irq,
    output logic [7:0]    keycode,
    output logic          pause_core,
    output logic          overflow,
    output logic [CW-1:0] fifo_count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    kb_state_e  state, state_next;
    logic       req_push, req_ext, pause_toggle;
    logic [7:0] req_code;
    logic       need_two, has_one, has_two, push_try, push_ok, push_lost, ff_write;
    logic       overrun_pending;
    logic [7:0] gap_cnt;
    logic       wr_en, wr_two, pop;
    logic [7:0] wr_data0, wr_data1, head;

    // Decoder: prefixes only move the FSM; the byte completing a sequence requests a push.
    always_comb begin
        state_next   = state;
        req_push     = 1'b0;
        req_ext      = 1'b0;
        req_code     = xlat(rx_data);
        pause_toggle = 1'b0;
        if (reset_keyboard || rx_error) begin
            state_next = ST_IDLE;
        end else if (rx_valid) begin
            case (state)
                ST_IDLE: begin
                    if (rx_data == PS2_BREAK)      state_next = ST_BRK;
                    else if (rx_data == PS2_EXT)   state_next = ST_EXT;
                    else if (rx_data == PS2_ACK || rx_data == PS2_ECHO || rx_data == PS2_RESEND) begin
                        state_next = ST_IDLE;
                    end else if (rx_data != PAUSE_CODE) req_push = 1'b1;
                end
                ST_BRK: begin
                    state_next = ST_IDLE;
                    if (rx_data == PAUSE_CODE) pause_toggle = 1'b1;
                    else begin
                        req_push = 1'b1;
                        req_code = xlat(rx_data) | XT_BREAK;
                    end
                end
                ST_EXT: begin
                    if (rx_data == PS2_BREAK) state_next = ST_EXT_BRK;
                    else begin
                        state_next = ST_IDLE;
                        req_push   = 1'b1;
                        req_ext    = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    req_push   = 1'b1;
                    req_ext    = 1'b1;
                    req_code   = xlat(rx_data) | XT_BREAK;
                end
            endcase
        end
    end

    // Space is judged on the pre-pop occupancy; an E0 pair is written whole or not at all.
    assign need_two  = req_ext && ENABLE_EXT;
    assign has_one   = fifo_count < DEPTH_C;
    assign has_two   = fifo_count <= DEPTH_C - CW'(2);
    assign push_try  = req_push && !pause_core;
    assign push_ok   = push_try && (need_two ? has_two : has_one);
    assign push_lost = push_try && !push_ok;
    assign ff_write  = overrun_pending && has_one && !push_ok && !reset_keyboard;

    always_comb begin
        wr_en    = 1'b0;
        wr_two   = 1'b0;
        wr_data0 = 8'h00;
        wr_data1 = 8'h00;
        if (reset_keyboard) begin
            wr_en    = 1'b1;
            wr_data0 = XT_BAT_OK;
        end else if (push_ok) begin
            wr_en    = 1'b1;
            wr_two   = need_two;
            wr_data0 = need_two ? PS2_EXT : req_code;
            wr_data1 = req_code;
        end else if (ff_write) begin
            wr_en    = 1'b1;
            wr_data0 = XT_OVERRUN;
        end
    end

    // irq is held low for IRQ_GAP cycles after each pop so the PIC sees one edge per code.
    assign irq     = (fifo_count != '0) && (gap_cnt == 8'd0);
    assign keycode = irq ? head : 8'h00;
    assign pop     = clear_keycode && irq && !reset_keyboard;

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= ST_IDLE;
            pause_core      <= 1'b0;
            overflow        <= 1'b0;
            overrun_pending <= 1'b0;
            gap_cnt         <= 8'd0;
        end else begin
            state <= state_next;
            if (pause_toggle) pause_core <= ~pause_core;
            if (reset_keyboard) begin
                overflow        <= 1'b0;
                overrun_pending <= 1'b0;
                gap_cnt         <= 8'd0;
            end else begin
                if (push_lost) overflow <= 1'b1;
                // A new loss or error in the same cycle as an FF write keeps another FF owed.
                if (push_lost || rx_error) overrun_pending <= 1'b1;
                else if (ff_write)         overrun_pending <= 1'b0;
                if (pop)                   gap_cnt <= 8'(IRQ_GAP);
                else if (gap_cnt != 8'd0)  gap_cnt <= gap_cnt - 8'd1;
            end
        end
    end

    ps2kb_code_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .flush    (reset_keyboard),
        .wr_en    (wr_en),
        .wr_two   (wr_two),
        .wr_data0 (wr_data0),
        .wr_data1 (wr_data1),
        .pop      (pop),
        .head     (head),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_ps2kb_xt_scancode_queue.sv
// Bench for ps2kb_xt_scancode_queue (FIFO_DEPTH=4, IRQ_GAP=2).
// u_dut runs with ENABLE_EXT=1 and is tracked by a queue-based reference model;
// u_dut2 shares the inputs with ENABLE_EXT=0 and is checked in the vector table.
module tb_ps2kb_xt_scancode_queue;

    localparam int DEPTH = 4;
    localparam int GAP   = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       rx_valid, rx_error, clear_keycode, reset_keyboard;
    logic [7:0] rx_data;
    logic       irq, pause_core, overflow;
    logic [7:0] keycode;
    logic [2:0] fifo_count;
    logic       irq2, pause_core2, overflow2;
    logic [7:0] keycode2;
    logic [2:0] fifo_count2;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    ps2kb_xt_scancode_queue #(.FIFO_DEPTH(DEPTH), .IRQ_GAP(GAP), .PAUSE_CODE(8'h78), .ENABLE_EXT(1'b1)) u_dut (
        .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_error(rx_error),
        .clear_keycode(clear_keycode), .reset_keyboard(reset_keyboard), .irq(irq), .keycode(keycode),
        .pause_core(pause_core), .overflow(overflow), .fifo_count(fifo_count)
    );

    ps2kb_xt_scancode_queue #(.FIFO_DEPTH(DEPTH), .IRQ_GAP(GAP), .PAUSE_CODE(8'h78), .ENABLE_EXT(1'b0)) u_dut2 (
        .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_error(rx_error),
        .clear_keycode(clear_keycode), .reset_keyboard(reset_keyboard), .irq(irq2), .keycode(keycode2),
        .pause_core(pause_core2), .overflow(overflow2), .fifo_count(fifo_count2)
    );

    // ---------------- reference model ----------------
    logic [7:0] xt_tab [logic [7:0]];
    logic [7:0] mq [$];
    bit         m_brk, m_ext, m_pause, m_ovf, m_pend;
    int         m_gap;

    function automatic logic [7:0] model_xlat(input logic [7:0] b);
        return xt_tab.exists(b) ? xt_tab[b] : 8'h00;
    endfunction

    function automatic bit m_irq();
        return (mq.size() != 0) && (m_gap == 0);
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_brk = 0; m_ext = 0; m_pause = 0; m_ovf = 0; m_pend = 0; m_gap = 0;
    endfunction

    function automatic void model_step(input bit rk, input bit err, input bit v, input logic [7:0] d, input bit clr);
        logic [7:0] w [$];
        logic [7:0] xc;
        bit want = 0, pushed = 0, lost = 0, ff, do_pop;
        int free_slots = DEPTH - mq.size();
        do_pop = clr && m_irq();
        if (rk) begin
            mq.delete();
            mq.push_back(8'hAA);
            m_brk = 0; m_ext = 0; m_pend = 0; m_ovf = 0; m_gap = 0;
            return;
        end
        if (err) begin
            m_brk = 0; m_ext = 0;
        end else if (v) begin
            xc = model_xlat(d);
            if (m_brk) begin
                if (!m_ext && d == 8'h78) m_pause = !m_pause;
                else begin
                    want = 1;
                    if (m_ext) w.push_back(8'hE0);
                    w.push_back(xc | 8'h80);
                end
                m_brk = 0; m_ext = 0;
            end else if (d == 8'hF0) m_brk = 1;
            else if (!m_ext && d == 8'hE0) m_ext = 1;
            else if (!m_ext && (d == 8'hFA || d == 8'hEE || d == 8'hFE)) begin
            end else begin
                if (m_ext || d != 8'h78) begin
                    want = 1;
                    if (m_ext) w.push_back(8'hE0);
                    w.push_back(xc);
                end
                m_ext = 0;
            end
        end
        if (want && !m_pause) begin
            if (w.size() <= free_slots) pushed = 1;
            else lost = 1;
        end
        ff = m_pend && (free_slots >= 1) && !pushed;
        if (do_pop) begin
            void'(mq.pop_front());
            m_gap = GAP;
        end else if (m_gap > 0) m_gap--;
        if (pushed) foreach (w[i]) mq.push_back(w[i]);
        if (ff) mq.push_back(8'hFF);
        if (lost) m_ovf = 1;
        if (lost || err) m_pend = 1;
        else if (ff) m_pend = 0;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [7:0] ek;
        ek = 8'h00;
        if (m_irq()) ek = mq[0];
        check("irq", {31'd0, irq}, {31'd0, m_irq()});
        check("keycode", {24'd0, keycode}, {24'd0, ek});
        check("fifo_count", {29'd0, fifo_count}, mq.size());
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        check("pause_core", {31'd0, pause_core}, {31'd0, m_pause});
    endtask

    // Inputs are driven 1 time unit after a rising edge and outputs sampled 1 unit after the next one.
    task automatic step(input bit rk, input bit err, input bit v, input logic [7:0] d, input bit clr);
        reset_keyboard = rk; rx_error = err; rx_valid = v; rx_data = d; clear_keycode = clr;
        @(posedge clock);
        #1;
        model_step(rk, err, v, d, clr);
        reset_keyboard = 0; rx_error = 0; rx_valid = 0; clear_keycode = 0;
        compare_all();
    endtask

    task automatic rx(input logic [7:0] d);
        step(0, 0, 1, d, 0);
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        int n = 0;
        while (!m_irq() && n < 8) begin
            step(0, 0, 0, 8'h00, 0);
            n++;
        end
        check({name, "_irq"}, {31'd0, irq}, 32'd1);
        check(name, {24'd0, keycode}, {24'd0, exp});
        step(0, 0, 0, 8'h00, 1);
    endtask

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         clr;
        bit         e_irq;
        logic [7:0] e_key;
        int         e_cnt;
        bit         e_pause;
        logic [7:0] e_key2;
        int         e_cnt2;
    } vec_t;

    vec_t vec [26];
    logic [7:0] key_list [16] = '{8'h1C, 8'h1B, 8'h23, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                                  8'h36, 8'h75, 8'h74, 8'h6B, 8'h72, 8'h5A, 8'h29, 8'h78};

    initial begin
        xt_tab[8'h1C] = 8'h1E; xt_tab[8'h1B] = 8'h1F; xt_tab[8'h23] = 8'h20; xt_tab[8'h16] = 8'h02;
        xt_tab[8'h1E] = 8'h03; xt_tab[8'h26] = 8'h04; xt_tab[8'h25] = 8'h05; xt_tab[8'h2E] = 8'h06;
        xt_tab[8'h36] = 8'h07; xt_tab[8'h75] = 8'h48; xt_tab[8'h74] = 8'h4D; xt_tab[8'h6B] = 8'h4B;
        xt_tab[8'h72] = 8'h50; xt_tab[8'h5A] = 8'h1C; xt_tab[8'h29] = 8'h39; xt_tab[8'h78] = 8'h57;

        //            v  d      clr irq key    cnt pause key2  cnt2
        vec[0]  = '{1, 8'h1C, 0, 1, 8'h1E, 1, 0, 8'h1E, 1};
        vec[1]  = '{0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00, 0};
        vec[2]  = '{1, 8'hF0, 0, 0, 8'h00, 0, 0, 8'h00, 0};
        vec[3]  = '{1, 8'h1C, 0, 1, 8'h9E, 1, 0, 8'h9E, 1};
        vec[4]  = '{0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00, 0};
        vec[5]  = '{1, 8'hE0, 0, 0, 8'h00, 0, 0, 8'h00, 0};
        vec[6]  = '{1, 8'h75, 0, 1, 8'hE0, 2, 0, 8'h48, 1};
        vec[7]  = '{1, 8'hE0, 0, 1, 8'hE0, 2, 0, 8'h48, 1};
        vec[8]  = '{1, 8'hF0, 0, 1, 8'hE0, 2, 0, 8'h48, 1};
        vec[9]  = '{1, 8'h75, 0, 1, 8'hE0, 4, 0, 8'h48, 2};
        vec[10] = '{0, 8'h00, 1, 0, 8'h00, 3, 0, 8'h00, 1};
        vec[11] = '{0, 8'h00, 0, 0, 8'h00, 3, 0, 8'h00, 1};
        vec[12] = '{0, 8'h00, 0, 1, 8'h48, 3, 0, 8'hC8, 1};
        vec[13] = '{0, 8'h00, 1, 0, 8'h00, 2, 0, 8'h00, 0};
        vec[14] = '{0, 8'h00, 0, 0, 8'h00, 2, 0, 8'h00, 0};
        vec[15] = '{0, 8'h00, 0, 1, 8'hE0, 2, 0, 8'h00, 0};
        vec[16] = '{0, 8'h00, 1, 0, 8'h00, 1, 0, 8'h00, 0};
        vec[17] = '{0, 8'h00, 0, 0, 8'h00, 1, 0, 8'h00, 0};
        vec[18] = '{0, 8'h00, 0, 1, 8'hC8, 1, 0, 8'h00, 0};
        vec[19] = '{0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00, 0};
        vec[20] = '{1, 8'hF0, 0, 0, 8'h00, 0, 0, 8'h00, 0};
        vec[21] = '{1, 8'h78, 0, 0, 8'h00, 0, 1, 8'h00, 0};
        vec[22] = '{1, 8'h1C, 0, 0, 8'h00, 0, 1, 8'h00, 0};
        vec[23] = '{1, 8'hF0, 0, 0, 8'h00, 0, 1, 8'h00, 0};
        vec[24] = '{1, 8'h78, 0, 0, 8'h00, 0, 0, 8'h00, 0};
        vec[25] = '{1, 8'h78, 0, 0, 8'h00, 0, 0, 8'h00, 0};

        reset = 1; rx_valid = 0; rx_data = 8'h00; rx_error = 0; clear_keycode = 0; reset_keyboard = 0;
        repeat (3) @(posedge clock);
        #1;
        reset = 0;
        model_reset();
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_keycode", {24'd0, keycode}, 32'h00);
        check("rst_count", {29'd0, fifo_count}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_pause", {31'd0, pause_core}, 32'd0);
        check("rst_count2", {29'd0, fifo_count2}, 32'd0);

        // Make/break, extended pairs (both ENABLE_EXT settings), irq gap, pause toggle.
        for (int i = 0; i < 26; i++) begin
            step(0, 0, vec[i].v, vec[i].d, vec[i].clr);
            check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vec[i].e_irq});
            check($sformatf("vec%0d_key", i), {24'd0, keycode}, {24'd0, vec[i].e_key});
            check($sformatf("vec%0d_cnt", i), {29'd0, fifo_count}, vec[i].e_cnt);
            check($sformatf("vec%0d_pause", i), {31'd0, pause_core}, {31'd0, vec[i].e_pause});
            check($sformatf("vec%0d_key2", i), {24'd0, keycode2}, {24'd0, vec[i].e_key2});
            check($sformatf("vec%0d_cnt2", i), {29'd0, fifo_count2}, vec[i].e_cnt2);
        end

        // Six makes into a depth-4 queue with no clears: last two lost, FF follows the first pop.
        rx(8'h16); rx(8'h1E); rx(8'h26); rx(8'h25); rx(8'h2E); rx(8'h36);
        check("t3_overflow", {31'd0, overflow}, 32'd1);
        check("t3_full", {29'd0, fifo_count}, 32'd4);
        pop_expect("t3_pop0", 8'h02);
        step(0, 0, 0, 8'h00, 0);
        check("t3_ff_fill", {29'd0, fifo_count}, 32'd4);
        pop_expect("t3_pop1", 8'h03);
        pop_expect("t3_pop2", 8'h04);
        pop_expect("t3_pop3", 8'h05);
        pop_expect("t3_pop_ff", 8'hFF);
        check("t3_empty", {29'd0, fifo_count}, 32'd0);

        // Three queued, E0 pair does not fit: dropped whole; FF enters as the head is popped.
        step(1, 0, 0, 8'h00, 0);
        rx(8'h1B); rx(8'h23);
        check("t4_ovf_clear", {31'd0, overflow}, 32'd0);
        rx(8'hE0); rx(8'h74);
        check("t4_pair_dropped", {29'd0, fifo_count}, 32'd3);
        check("t4_overflow", {31'd0, overflow}, 32'd1);
        step(0, 0, 0, 8'h00, 1);
        check("t4_pop_and_ff", {29'd0, fifo_count}, 32'd3);
        pop_expect("t4_pop0", 8'h1F);
        pop_expect("t4_pop1", 8'h20);
        pop_expect("t4_pop_ff", 8'hFF);

        // Keyboard reset with three queued and pause active, then rx_error.
        rx(8'h1C); rx(8'h16); rx(8'h1E);
        rx(8'hF0); rx(8'h78);
        step(1, 0, 0, 8'h00, 0);
        check("t6_count", {29'd0, fifo_count}, 32'd1);
        check("t6_keycode", {24'd0, keycode}, 32'hAA);
        check("t6_irq", {31'd0, irq}, 32'd1);
        check("t6_overflow", {31'd0, overflow}, 32'd0);
        check("t6_pause_kept", {31'd0, pause_core}, 32'd1);
        rx(8'hF0); rx(8'h78);
        step(0, 1, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0);
        check("t6_ff_queued", {29'd0, fifo_count}, 32'd2);
        pop_expect("t6_pop_aa", 8'hAA);
        pop_expect("t6_pop_ff", 8'hFF);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bit rk, err, v, clr;
            logic [7:0] d;
            int r;
            rk  = ($urandom_range(0, 199) == 0);
            err = ($urandom_range(0, 39) == 0);
            v   = ($urandom_range(0, 9) < 6);
            clr = ($urandom_range(0, 9) < 3);
            r   = $urandom_range(0, 99);
            if (r < 15)      d = 8'hF0;
            else if (r < 30) d = 8'hE0;
            else if (r < 34) d = 8'hFA;
            else             d = key_list[$urandom_range(0, 15)];
            step(rk, err, v, d, clr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
